uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte presented with a single-cycle write strobe (the receiver's done pulse) into a circular buffer. The host or bus side drains it through a read-enable interface. Fill-level flags, a fill count and sticky overflow/underflow error flags let software pace reads and detect lost bytes.

## Interface
- DATA_WIDTH, 8: byte width.
- DEPTH, 16: entries; power of two, at least 2.
- AFULL_THRESH, 12: `almost_full` asserts when count is at least this value; range 1..DEPTH.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_data  in  DATA_WIDTH  received byte.
- wr_en  in  1  write strobe; one cycle per byte, driven from the receiver's done pulse.
- rd_en  in  1  read/pop request.
- clear_err  in  1  clears `overflow` and `underflow`.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  `rd_data` is valid (meaning depends on mode; see Configuration).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH x DATA_WIDTH register array.
- Pointers: `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide. Each advances by 1 and wraps DEPTH-1 -> 0 naturally.
- `count` is a separate register, updated per edge as follows:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both or neither are accepted.
- Accepted read: `rd_en` && !empty.
- Accepted write: `wr_en` && (!full || accepted read). Writing while full succeeds only if a read pops in the same cycle.
- Dropped write (`wr_en` && full && no accepted read):
  - Array, pointers and count are unchanged.
  - `overflow` is set.
- Read while empty: ignored; `underflow` is set.
- Simultaneous write and read while empty: the write is accepted and the read is ignored. `underflow` is set, and count goes 0 -> 1.
- Sticky flags: `clear_err` clears both. If a set event and `clear_err` occur in the same cycle, set wins.
- Flags:
  - `empty`, `full` and `almost_full` decode combinationally from the registered `count`.
  - They therefore change on the edge that updates `count`.
- Reset (async, any time, including mid-burst):
  - Pointers = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, full = 0, almost_full = 0.
  - Array contents are don't-care.
  - Any in-flight read is discarded.

## Timing
- Write latency: a byte strobed at edge N is counted at edge N. It is readable starting in the cycle after N.
- Standard mode:
  - An accepted read at edge N registers `mem[rd_ptr]` into `rd_data` at edge N.
  - `rd_valid` is high for exactly the cycle after N.
  - `rd_data` holds its last value until the next accepted read.
- Back-to-back reads on consecutive cycles give one byte per cycle.
- Sustained throughput is one write and one read per cycle.
- No combinational path exists from `wr_en` or `rd_en` to any output.

## Configuration
- Macro: `UART_RX_FIFO_FWFT_EN` (first-word fall-through).
- Defined:
  - `rd_data` = `mem[rd_ptr]`, combinational from registered state.
  - `rd_valid` = !empty.
  - `rd_en` acknowledges and pops the displayed byte; the next byte (if any) appears in the following cycle.
  - A byte written into an empty FIFO at edge N is visible on `rd_data` with `rd_valid` = 1 in the cycle after N.
- Not defined: standard registered-read mode as described under Timing.
- Accept, drop, count and error-flag rules are identical in both modes.

## Test plan
- Reset, then write 0xA5, 0x3C, 0xFF on three separate cycles -> count = 3, empty = 0. Three reads return 0xA5, 0x3C, 0xFF in order, each with `rd_valid` for one cycle. Afterwards count = 0 and empty = 1.
- Fill with 16 bytes 0x00..0x0F (DEPTH = 16):
  - almost_full rises when count reaches 12.
  - full = 1 at count 16.
  - A 17th write of 0x55 is dropped: overflow = 1, count stays 16, and the readback is 0x00..0x0F.
- While full, assert `wr_en` (0x77) and `rd_en` in the same cycle -> count stays 16, the read returns 0x00, and 0x77 is the last byte read out after a full drain. No overflow is flagged.
- Read while empty -> underflow = 1, rd_valid stays 0, count stays 0. Pulse `clear_err` -> underflow = 0. `clear_err` coinciding with a new empty read -> underflow remains 1.
- Pointer wrap: perform 40 write/read pairs of an incrementing pattern 0x00..0x27 with occupancy cycling 0..5 -> every byte reads back in order with no overflow or underflow.
- Assert reset asynchronously mid-burst with count = 7 -> all outputs take their reset values immediately. The next write of 0x42 reads back as 0x42.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Summary  : Receive-side circular byte buffer behind the UART receiver,
//             with fill flags, occupancy count and sticky error flags.
//             Define UART_RX_FIFO_FWFT_EN for first-word fall-through reads.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   input  logic                        wr_en,
   input  logic                        rd_en,
   input  logic                        clear_err,
   output logic [DATA_WIDTH-1:0]       rd_data,
   output logic                        rd_valid,
   output logic                        empty,
   output logic                        full,
   output logic                        almost_full,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
   localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  w_rd_accept;
   logic                  w_wr_accept;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CW'(DEPTH));
   assign almost_full = (count_q >= CW'(AFULL_THRESH));
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

   // A write into a full buffer is only legal when a pop frees the slot.
   assign w_rd_accept = rd_en && !empty;
   assign w_wr_accept = wr_en && (!full || w_rd_accept);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (w_wr_accept) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (w_rd_accept) rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      case ({w_wr_accept, w_rd_accept})
         2'b10:   count_d = count_q + C_CNT_ONE;
         2'b01:   count_d = count_q - C_CNT_ONE;
         default: count_d = count_q;
      endcase
      if (clear_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      // Set events take priority over a coincident clear.
      if (wr_en && !w_wr_accept) overflow_d  = 1'b1;
      if (rd_en && empty)        underflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_accept) mem[wr_ptr_q] <= wr_data;
   end

`ifdef UART_RX_FIFO_FWFT_EN
   // Head entry is shown directly; forced to zero while nothing is stored.
   assign rd_data  = empty ? '0 : mem[rd_ptr_q];
   assign rd_valid = !empty;
`else
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= w_rd_accept;
         if (w_rd_accept) rd_data_q <= mem[rd_ptr_q];
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Summary  : Directed self-checking bench for uart_rx_fifo (registered-read
//             mode, DEPTH 16, AFULL_THRESH 12).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   logic       clk;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       rd_en;
   logic       clear_err;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int errors = 0;
   int checks = 0;

   uart_rx_fifo #(
      .DATA_WIDTH   (8),
      .DEPTH        (16),
      .AFULL_THRESH (12)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .clear_err   (clear_err),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      wr_data = b;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++;
      if ({empty, full, almost_full} !== 3'b100) begin
         errors++; $display("FAIL reset_flags got e/f/af=%b exp=100", {empty, full, almost_full});
      end
      checks++;
      if ({rd_valid, overflow, underflow} !== 3'b000 || rd_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got v/ov/un=%b data=%h exp=000 data=00",
                  {rd_valid, overflow, underflow}, rd_data);
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'hFF;
      for (int i = 0; i < 3; i++) push(exp_b[i]);
      checks++;
      if (count !== 5'd3 || empty !== 1'b0) begin
         errors++; $display("FAIL basic_fill got count=%0d empty=%b exp 3/0", count, empty);
      end
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1;
         step();
         rd_en = 1'b0;
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin
            errors++; $display("FAIL basic_read%0d got v=%b data=%h exp v=1 data=%h", i, rd_valid, rd_data, exp_b[i]);
         end
         step();
         checks++;
         if (rd_valid !== 1'b0 || rd_data !== exp_b[i]) begin
            errors++; $display("FAIL basic_hold%0d got v=%b data=%h exp v=0 data=%h", i, rd_valid, rd_data, exp_b[i]);
         end
      end
      checks++;
      if (count !== 5'd0 || empty !== 1'b1) begin
         errors++; $display("FAIL basic_drain got count=%0d empty=%b exp 0/1", count, empty);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         checks++;
         if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 12) || full !== (i + 1 == 16)) begin
            errors++;
            $display("FAIL fill%0d got count=%0d af=%b full=%b exp count=%0d af=%b full=%b",
                     i, count, almost_full, full, i + 1, (i + 1 >= 12), (i + 1 == 16));
         end
      end
      push(8'h55);
      checks++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         errors++; $display("FAIL overflow got ov=%b count=%0d exp 1/16", overflow, count);
      end
      rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
            errors++; $display("FAIL fill_read%0d got v=%b data=%h exp v=1 data=%h", i, rd_valid, rd_data, 8'(i));
         end
      end
      rd_en = 1'b0;
      step();
      checks++;
      if (count !== 5'd0 || rd_valid !== 1'b0) begin
         errors++; $display("FAIL fill_drain got count=%0d v=%b exp 0/0", count, rd_valid);
      end
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < 16; i++) push(8'(i));
      wr_data = 8'h77;
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      step();
      wr_en   = 1'b0;
      checks++;
      if (count !== 5'd16 || rd_data !== 8'h00 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_simul got count=%0d data=%h ov=%b exp 16/00/0", count, rd_data, overflow);
      end
      for (int i = 1; i <= 16; i++) begin
         step();
         checks++;
         if (rd_data !== ((i == 16) ? 8'h77 : 8'(i))) begin
            errors++;
            $display("FAIL full_drain%0d got data=%h exp=%h", i, rd_data, (i == 16) ? 8'h77 : 8'(i));
         end
      end
      rd_en = 1'b0;
      step();
      checks++;
      if (count !== 5'd0 || overflow !== 1'b0) begin
         errors++; $display("FAIL full_end got count=%0d ov=%b exp 0/0", count, overflow);
      end
   endtask

   task automatic test_underflow();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++;
      if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd0) begin
         errors++;
         $display("FAIL underflow got un=%b v=%b count=%0d exp 1/0/0", underflow, rd_valid, count);
      end
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      checks++;
      if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got=%b exp=0", underflow); end
      clear_err = 1'b1;
      rd_en     = 1'b1;
      step();
      clear_err = 1'b0;
      rd_en     = 1'b0;
      checks++;
      if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set_wins got=%b exp=1", underflow); end
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      // Write and read together on an empty buffer: write lands, read flags.
      wr_data = 8'h9E;
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      step();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      checks++;
      if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL empty_simul got count=%0d un=%b v=%b exp 1/1/0", count, underflow, rd_valid);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++;
      if (rd_data !== 8'h9E || rd_valid !== 1'b1 || count !== 5'd0) begin
         errors++;
         $display("FAIL empty_simul_read got data=%h v=%b count=%0d exp 9e/1/0", rd_data, rd_valid, count);
      end
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
   endtask

   task automatic test_wrap();
      int bad = 0;
      for (int blk = 0; blk < 8; blk++) begin
         for (int j = 0; j < 5; j++) push(8'(blk * 5 + j));
         rd_en = 1'b1;
         for (int j = 0; j < 5; j++) begin
            step();
            if (rd_data !== 8'(blk * 5 + j) || rd_valid !== 1'b1) bad++;
         end
         rd_en = 1'b0;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL wrap_data got bad_reads=%0d exp=0", bad); end
      checks++;
      if ({overflow, underflow, empty} !== 3'b001) begin
         errors++; $display("FAIL wrap_flags got ov/un/e=%b exp=001", {overflow, underflow, empty});
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
      checks++;
      if (count !== 5'd7) begin errors++; $display("FAIL prereset_count got=%0d exp=7", count); end
      rd_en = 1'b1;
      step();
      wr_data = 8'hEE;
      wr_en   = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (count !== 5'd0 || {empty, full, almost_full} !== 3'b100 ||
          {rd_valid, overflow, underflow} !== 3'b000 || rd_data !== 8'h00) begin
         errors++;
         $display("FAIL async_reset got count=%0d e/f/af=%b v/ov/un=%b data=%h exp 0/100/000/00",
                  count, {empty, full, almost_full}, {rd_valid, overflow, underflow}, rd_data);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      step();
      reset = 1'b0;
      step();
      push(8'h42);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++;
      if (rd_data !== 8'h42 || rd_valid !== 1'b1 || count !== 5'd0) begin
         errors++;
         $display("FAIL post_reset_read got data=%h v=%b count=%0d exp 42/1/0", rd_data, rd_valid, count);
      end
   endtask

   initial begin
      reset     = 1'b1;
      wr_data   = 8'h00;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      clear_err = 1'b0;
      step();
      step();
      test_reset();
      reset = 1'b0;
      step();
      test_basic();
      test_fill_overflow();
      test_full_simul();
      test_underflow();
      test_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
